// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// The saturation helpers are only referenced when ADDSUB_SAT_EN is defined.
package addsub_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Largest positive two's-complement value of the given width (width <= 64).
    function automatic logic [63:0] sat_max(int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width (width <= 64).
    function automatic logic [63:0] sat_min(int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Operand/result handshake bundle for digit_serial_addsub.
// The master drives operands and accepts results; the slave is the adder.
interface digit_serial_addsub_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             v;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, v
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, v
    );
endinterface

// File: rtl/ripple_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder slice.
// c_msb_o is the carry into the top bit, used for signed overflow detection.
module ripple_digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);
    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < int'(DIGIT); i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o     = c[DIGIT];
    assign c_msb_o = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle two's-complement add/sub processing DIGIT bits per clock.
// Optional macro ADDSUB_SAT_EN replaces overflowing results with the signed max/min.
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_addsub_if.slave bus
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned IW   = $clog2(WIDTH);

`ifdef ADDSUB_SAT_EN
    localparam logic [63:0] SatMax64 = sat_max(WIDTH);
    localparam logic [63:0] SatMin64 = sat_min(WIDTH);
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [IW-1:0]    idx;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_cmsb;
    logic             last_dig;

    assign idx      = IW'(cnt_q) * IW'(DIGIT);
    assign last_dig = (cnt_q == CW'(NDIG - 1));

    ripple_digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_i    (a_q[idx +: DIGIT]),
        .b_i    (b_q[idx +: DIGIT]),
        .c_i    (carry_q),
        .s_o    (dig_sum),
        .c_o    (dig_cout),
        .c_msb_o(dig_cmsb)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        v_d         = v_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                out_valid_d = 1'b0;
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                res_d[idx +: DIGIT] = dig_sum;
                carry_d             = dig_cout;
                cnt_d               = cnt_q + CW'(1);
                if (last_dig) begin
                    state_d = StDone;
                    sum_d   = res_d;
                    cout_d  = dig_cout;
                    v_d     = dig_cmsb ^ dig_cout;
`ifdef ADDSUB_SAT_EN
                    if (dig_cmsb ^ dig_cout) begin
                        sum_d = a_q[WIDTH-1] ? SatMin64[WIDTH-1:0] : SatMax64[WIDTH-1:0];
                    end
`endif
                end
            end
            StDone: begin
                // out_valid rises one cycle after DONE entry, giving NDIG+1 latency
                if (out_valid_q && bus.out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            v_q         <= v_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.v         = v_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: five instances (DIGIT 4,1,2,8,16 at WIDTH 16), each
// checked every cycle against an arithmetic model; honours ADDSUB_SAT_EN when defined.
module tb_digit_serial_addsub;
    localparam int NDUT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NDUT-1:0] drv_valid;
    logic [NDUT-1:0] drv_sub;
    logic [NDUT-1:0] drv_ready;
    logic [15:0]     drv_a [NDUT];
    logic [15:0]     drv_b [NDUT];

    wire [NDUT-1:0] o_iready;
    wire [NDUT-1:0] o_ovalid;
    wire [NDUT-1:0] o_cout;
    wire [NDUT-1:0] o_v;
    wire [15:0]     o_sum [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d at %0t: got %0h want %0h", name, g, $time, act, exp);
        end
    endtask

    function automatic int dig_of(int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    // Reference: {cout, v, sum} from plain integer arithmetic.
    function automatic logic [17:0] ref_op(logic [15:0] a, logic [15:0] b, logic s);
        int          sa;
        int          sb;
        int          r;
        logic        c;
        logic        ov;
        logic [15:0] res;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        r   = s ? (sa - sb) : (sa + sb);
        ov  = (r > 32767) || (r < -32768);
        c   = s ? (a >= b) : ((int'(a) + int'(b)) > 65535);
        res = s ? (a - b) : (a + b);
`ifdef ADDSUB_SAT_EN
        if (ov) res = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {c, ov, res};
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
        localparam int NDIG = 16 / D;

        digit_serial_addsub_if #(.WIDTH(16)) bus ();

        assign bus.in_valid  = drv_valid[g];
        assign bus.a         = drv_a[g];
        assign bus.b         = drv_b[g];
        assign bus.sub       = drv_sub[g];
        assign bus.out_ready = drv_ready[g];
        assign o_iready[g]   = bus.in_ready;
        assign o_ovalid[g]   = bus.out_valid;
        assign o_sum[g]      = bus.sum;
        assign o_cout[g]     = bus.cout;
        assign o_v[g]        = bus.v;

        digit_serial_addsub #(
            .WIDTH(16),
            .DIGIT(D)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );

        // phase 0 idle, 1 computing, 2 result pending
        int          phase = 0;
        int          cnt   = 0;
        logic [15:0] e_sum = '0;
        logic        e_cout = 1'b0;
        logic        e_v    = 1'b0;
        logic [17:0] pend  = '0;

        always @(negedge clk) begin
            case (phase)
                0: begin
                    chk("idle_in_ready", g, o_iready[g], 1);
                    chk("idle_out_valid", g, o_ovalid[g], 0);
                    chk("held_sum", g, o_sum[g], e_sum);
                    chk("held_cout", g, o_cout[g], e_cout);
                    chk("held_v", g, o_v[g], e_v);
                end
                1: begin
                    chk("busy_in_ready", g, o_iready[g], 0);
                    chk("busy_out_valid", g, o_ovalid[g], 0);
                end
                default: begin
                    chk("done_in_ready", g, o_iready[g], 0);
                    chk("done_out_valid", g, o_ovalid[g], 1);
                    chk("result_sum", g, o_sum[g], e_sum);
                    chk("result_cout", g, o_cout[g], e_cout);
                    chk("result_v", g, o_v[g], e_v);
                end
            endcase
            if (rst) begin
                phase  = 0;
                e_sum  = '0;
                e_cout = 1'b0;
                e_v    = 1'b0;
            end else begin
                case (phase)
                    0: if (drv_valid[g]) begin
                        pend  = ref_op(drv_a[g], drv_b[g], drv_sub[g]);
                        phase = 1;
                        cnt   = 0;
                    end
                    1: if (cnt == NDIG) begin
                        phase  = 2;
                        e_sum  = pend[15:0];
                        e_v    = pend[16];
                        e_cout = pend[17];
                    end else begin
                        cnt++;
                    end
                    default: if (drv_ready[g]) phase = 0;
                endcase
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_accept(int g, logic [15:0] a, logic [15:0] b, logic s);
        drv_valid[g] = 1'b1;
        drv_a[g]     = a;
        drv_b[g]     = b;
        drv_sub[g]   = s;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (o_iready[g]) break;
        end
        chk("accept_seen", g, o_iready[g], 1);
        @(posedge clk);
        #1;
        drv_valid[g] = 1'b0;
    endtask

    task automatic get_result(int g, bit noise, int hold, output int lat,
                              output logic [15:0] rs, output logic rc, output logic rv);
        lat = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (noise) begin
                drv_valid[g] = 1'($urandom_range(0, 1));
                drv_a[g]     = 16'($urandom);
            end
            if (o_ovalid[g]) begin
                lat = i;
                break;
            end
        end
        chk("out_valid_seen", g, o_ovalid[g], 1);
        rs = o_sum[g];
        rc = o_cout[g];
        rv = o_v[g];
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (noise) drv_valid[g] = 1'($urandom_range(0, 1));
        end
        drv_valid[g] = 1'b0;
        drv_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        drv_ready[g] = 1'b0;
    endtask

    task automatic dir_op(string name, logic [15:0] a, logic [15:0] b, logic s,
                          logic [15:0] es, logic ec, logic ev);
        int          lat;
        logic [15:0] rs;
        logic        rc;
        logic        rv;
        send_accept(0, a, b, s);
        get_result(0, 1'b0, 0, lat, rs, rc, rv);
        chk({name, "_latency"}, 0, lat, 5);
        chk({name, "_sum"}, 0, rs, es);
        chk({name, "_cout"}, 0, rc, ec);
        chk({name, "_v"}, 0, rv, ev);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_run(int g, int nops);
        int          lat;
        logic [15:0] rs;
        logic        rc;
        logic        rv;
        for (int n = 0; n < nops; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_accept(g, rnd16(), rnd16(), 1'($urandom_range(0, 1)));
            get_result(g, 1'b1, $urandom_range(0, 3), lat, rs, rc, rv);
            chk("rand_latency", g, lat, 16 / dig_of(g) + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        drv_valid = '0;
        drv_sub   = '0;
        drv_ready = '0;
        for (int g = 0; g < NDUT; g++) begin
            drv_a[g] = '0;
            drv_b[g] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_in_ready", 0, o_iready[0], 1);
        chk("reset_out_valid", 0, o_ovalid[0], 0);
        chk("reset_sum", 0, o_sum[0], 16'h0000);
        chk("reset_cout", 0, o_cout[0], 0);
        chk("reset_v", 0, o_v[0], 0);

        chk("model_pin_add", 0, 32'(ref_op(16'h1234, 16'h0FFF, 1'b0)), 32'h0000_2233);
        chk("model_pin_sub", 0, 32'(ref_op(16'h0007, 16'h0005, 1'b1)), 32'h0002_0002);
`ifdef ADDSUB_SAT_EN
        chk("model_pin_ovf", 0, 32'(ref_op(16'h7FFF, 16'h0001, 1'b0)), 32'h0001_7FFF);
`else
        chk("model_pin_ovf", 0, 32'(ref_op(16'h7FFF, 16'h0001, 1'b0)), 32'h0001_8000);
`endif

        dir_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        dir_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        dir_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
        dir_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        dir_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        dir_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        dir_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        // Backpressure: result held while in_valid is driven in DONE
        send_accept(0, 16'hA5A5, 16'h1111, 1'b0);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (o_ovalid[0]) break;
        end
        chk("bp_out_valid", 0, o_ovalid[0], 1);
        drv_valid[0] = 1'b1;
        drv_a[0]     = 16'h0101;
        drv_b[0]     = 16'h0202;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_sum", 0, o_sum[0], 16'hB6B6);
            chk("bp_cout", 0, o_cout[0], 0);
            chk("bp_v", 0, o_v[0], 0);
            chk("bp_in_ready", 0, o_iready[0], 0);
            chk("bp_out_valid_held", 0, o_ovalid[0], 1);
        end
        drv_valid[0] = 1'b0;
        drv_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        drv_ready[0] = 1'b0;
        chk("bp_release_in_ready", 0, o_iready[0], 1);
        chk("bp_release_out_valid", 0, o_ovalid[0], 0);
        chk("bp_release_sum", 0, o_sum[0], 16'hB6B6);

        // Reset during the second BUSY cycle aborts the operation
        send_accept(0, 16'h4444, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", 0, o_iready[0], 1);
        chk("abort_out_valid", 0, o_ovalid[0], 0);
        chk("abort_sum", 0, o_sum[0], 16'h0000);
        dir_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        fork
            rand_run(0, 30);
            rand_run(1, 30);
            rand_run(2, 30);
            rand_run(3, 30);
            rand_run(4, 30);
        join

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
